// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter, 8N1 frames LSB-first
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   byte_ready_i, data_in    one-cycle push strobe and the byte to queue
//   tx_o                     registered serial line, idle high
//   tx_busy_o                FSM not in IDLE
//   tx_done_o                pulse on the last cycle of each stop bit
//   fifo_full_o              queue full, stall request to the pipeline
//   fifo_count_o             queue occupancy
//   overflow_o               sticky flag: a push was dropped
// Build option: define UART_PARITY_EN to insert an even-parity bit before STOP (8E1).
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             byte_ready_i,
  input  logic [7:0]       data_in,
  output logic             tx_o,
  output logic             tx_busy_o,
  output logic             tx_done_o,
  output logic             fifo_full_o,
  output logic [CNT_W-1:0] fifo_count_o,
  output logic             overflow_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic full_q, ovf_q, ovf_d, tx_q, tx_d;
  logic tick, pop, push_ok;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      full_q  <= count_d == FULL;
      ovf_q   <= ovf_d;
      tx_q    <= tx_d;
    end
  end
  // Storage needs no reset: only entries written since the last reset are ever read.
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_q] <= data_in;
  always_comb begin
    tick    = baud_q == '0;
    state_d = state_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        state_d = START;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
`ifdef UART_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
        else bit_d = bit_q + 1'b1;
      end
`ifdef UART_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) begin
        pop     = count_q != '0;
        state_d = pop ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    shift_d = pop ? mem_q[rd_q] : shift_q;
    // Every state or bit change restarts a full bit period; the counter parks at zero otherwise.
    baud_d  = (state_d != state_q || bit_d != bit_q) ? BAUD_LOAD : tick ? baud_q : baud_q - 1'b1;
    // A pop in the same cycle frees a slot, so a push on a full queue still lands.
    push_ok = byte_ready_i && (count_q != FULL || pop);
    wr_d    = wr_q + PW'(push_ok);
    rd_d    = rd_q + PW'(pop);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    ovf_d   = ovf_q || (byte_ready_i && !push_ok);
    // tx is registered from next-state values so the line moves in step with the FSM.
`ifdef UART_PARITY_EN
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[bit_d] : state_d == PARITY ? ^shift_d : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[bit_d] : 1'b1;
`endif
  end
  always_comb begin
    tx_o         = tx_q;
    tx_busy_o    = state_q != IDLE;
    tx_done_o    = state_q == STOP && tick;
    fifo_full_o  = full_q;
    fifo_count_o = count_q;
    overflow_o   = ovf_q;
  end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Downstream consumer of the load/store unit's UART path.
- Each store to the UART address window (addrS[31:12] == 1) raises byte_ready_i for one cycle with the byte on data_in.
- This block queues those bytes in a small FIFO and serialises them LSB-first as 8N1 frames on tx_o.
- It exports back-pressure (fifo_full_o) so the pipeline hazard logic can stall UART stores.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200); legal range >= 2
FIFO_DEPTH, 4, byte entries in the TX queue; power of two, >= 2
CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
byte_ready_i  input  1  one-cycle push strobe from the load/store unit
data_in  input  8  byte to transmit, sampled when byte_ready_i=1
tx_o  output  1  serial line, idle high
tx_busy_o  output  1  high while the FSM is not in IDLE
tx_done_o  output  1  one-cycle pulse on the last cycle of each stop bit
fifo_full_o  output  1  count == FIFO_DEPTH (stall request to the pipeline)
fifo_count_o  output  CNT_W  current FIFO occupancy
overflow_o  output  1  sticky: a push was attempted while full and not popping

Behaviour:
Reset (rst_n=0, asynchronous):
- tx_o=1; tx_busy_o=0; tx_done_o=0; fifo_count_o=0; fifo_full_o=0; overflow_o=0.
- FSM goes to IDLE; read/write pointers, baud counter and bit index are cleared.
- Reset mid-frame aborts the frame immediately: tx_o returns to 1 asynchronously and queued bytes are discarded.

FIFO:
- Circular buffer with pointers that wrap modulo FIFO_DEPTH.
- Push is accepted when byte_ready_i=1 and either (count < FIFO_DEPTH) or a pop occurs in the same cycle.
- Simultaneous push and pop leaves count unchanged.
- A push that is not accepted is dropped and sets overflow_o=1 until reset.
- Pop happens only under FSM control (see below).
- A pop on an empty FIFO never occurs.
- fifo_full_o and fifo_count_o are registered and reflect state after the edge.

FSM states: IDLE, START, DATA, STOP.
- Baud counter: loaded with CLKS_PER_BIT-1 on every state/bit entry, decrements each cycle. "Tick" means the counter == 0.
- IDLE: tx_o=1. If count != 0, pop the head into shift_reg and go to START.
- START: tx_o=0. On tick go to DATA with bit_idx=0.
- DATA: tx_o=shift_reg[bit_idx]. On tick, if bit_idx==7 go to STOP, else increment bit_idx.
- STOP: tx_o=1. On tick, pulse tx_done_o.
  - If FIFO is non-empty, pop and go straight to START (no idle gap).
  - Otherwise go to IDLE.
- tx_o is driven from a register (glitch-free).

Latency and timing:
- Push at edge N into an empty FIFO with FSM in IDLE: pop at edge N+1; tx_o falls after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- A byte pushed during the frame in progress does not alter that frame.

Optional Feature:
UART_PARITY_EN:
- Defined: a PARITY state is inserted between DATA and STOP.
  - It transmits even parity (XOR of the 8 data bits) for one bit period.
  - Frame becomes 11*CLKS_PER_BIT cycles.
  - tx_done_o timing is still the last cycle of STOP.
- Undefined: no PARITY state; 8N1 only, with no parity logic in the netlist.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> tx_o=1, fifo_count_o=0, tx_busy_o=0 for 50 cycles.
- Single byte: CLKS_PER_BIT=4, push 0xA5 -> tx_o start bit low from the cycle after the pop.
  - Then bits 1,0,1,0,0,1,0,1, each 4 cycles, then stop high.
  - tx_done_o pulses once, 40 cycles after tx_o falls.
- Back-to-back: push 0x55, 0x0F, 0x80 on consecutive cycles -> fifo_count_o peaks at 2.
  - Three frames with no idle cycle between them; total 120 cycles of activity; 3 tx_done_o pulses.
- Full/overflow: FIFO_DEPTH=4, push 6 bytes in consecutive cycles while the first frame is in progress.
  - fifo_full_o=1 after the 5th push; the 6th push is dropped and overflow_o=1.
  - Exactly 5 frames are transmitted.
- Push on full with concurrent pop: fill the FIFO, then push on the STOP tick cycle -> push accepted, count stays 4, overflow_o stays 0.
- Reset mid-frame: assert rst_n during DATA bit 3 with 2 bytes queued.
  - tx_o=1 immediately; after release no frame is sent and count=0.
  - With UART_PARITY_EN, byte 0x07 gives parity bit 1 and an 11-bit frame.
